// File: rtl/bus_master_if.sv
// Master-side bus interface: turns one core access into one bus transaction.
// Optional ACCESS timeout abort is compiled in with BUS_TIMEOUT_EN.
module bus_master_if #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("bus_master_if: TIMEOUT out of range 2..65535");
   end

   logic [1:0]        state;
   logic [ADDR_W-1:0] l_addr;
   logic              l_rw;
   logic [DATA_W-1:0] l_wdata;
   logic              tmo;
   logic              finish;

`ifdef BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   assign tmo = (cnt == T_LAST);

   // ACCESS cycle counter: zeroed on entry, counts each ACCESS cycle
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (state == S_REQ && !bus_grnt_)
         cnt <= '0;
      else if (state == S_ACC && !finish)
         cnt <= cnt + 1'b1;
   end

   // abort flag: pulses with done when the slave never answered
   always_ff @(posedge clk) begin
      if (!rst_n)
         err <= 1'b0;
      else
         err <= (state == S_ACC) && bus_rdy_ && tmo;
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   // ACCESS ends on slave ready, or on timeout when enabled
   assign finish = !bus_rdy_ || tmo;

   // transaction FSM and all registered bus/core outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         l_addr      <= '0;
         l_rw        <= 1'b1;
         l_wdata     <= '0;
         rd_data     <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
         bus_req_    <= 1'b1;
         bus_as_     <= 1'b1;
         bus_rw      <= 1'b1;
         bus_addr    <= '0;
         bus_wr_data <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  l_addr   <= addr;
                  l_rw     <= rw;
                  l_wdata  <= wr_data;
                  bus_req_ <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (!bus_grnt_) begin
                  bus_addr    <= l_addr;
                  bus_rw      <= l_rw;
                  bus_wr_data <= l_rw ? '0 : l_wdata;
                  bus_as_     <= 1'b0;
                  state       <= S_ACC;
               end
            end
            S_ACC: begin
               if (finish) begin
                  if (!bus_rdy_ && l_rw)
                     rd_data <= bus_rd_data;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  bus_req_    <= 1'b1;
                  bus_as_     <= 1'b1;
                  bus_rw      <= 1'b1;
                  bus_addr    <= '0;
                  bus_wr_data <= '0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               busy        <= 1'b0;
               bus_req_    <= 1'b1;
               bus_as_     <= 1'b1;
               bus_rw      <= 1'b1;
               bus_addr    <= '0;
               bus_wr_data <= '0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: reset, read, write, back-to-back,
// ready-before-grant, and the timeout / no-timeout ACCESS behaviour.
module tb_bus_master_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        rw;
   logic [29:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        done;
   logic        err;
   logic        busy;
   logic        bus_req_;
   logic        bus_grnt_;
   logic [29:0] bus_addr;
   logic        bus_as_;
   logic        bus_rw;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_;

   int checks   = 0;
   int failures = 0;
   int dcount;

   bus_master_if #(
      .ADDR_W(30), .DATA_W(32), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .rw(rw),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .done(done), .err(err), .busy(busy),
      .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
      .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
      .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
      .bus_rdy_(bus_rdy_)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(string tag);
      chk({tag, "_req_"}, 32'(bus_req_), 32'd1);
      chk({tag, "_as_"}, 32'(bus_as_), 32'd1);
      chk({tag, "_rw"}, 32'(bus_rw), 32'd1);
      chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
      chk({tag, "_wd"}, bus_wr_data, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      req         = 1'b0;
      rw          = 1'b1;
      addr        = '0;
      wr_data     = '0;
      bus_grnt_   = 1'b1;
      bus_rdy_    = 1'b1;
      bus_rd_data = '0;
      tick();
      tick();
      rst_n = 1'b1;
      chk_idle("rst0");
      chk("rst0_rd", rd_data, 32'd0);

      // read, immediate grant, ready on 3rd ACCESS cycle
      req = 1'b1; rw = 1'b1; addr = 30'h0000010; bus_grnt_ = 1'b0;
      tick();
      chk("rd_req_", 32'(bus_req_), 32'd0);
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_as_pre", 32'(bus_as_), 32'd1);
      tick();
      chk("rd_as1", 32'(bus_as_), 32'd0);
      chk("rd_addr", 32'(bus_addr), 32'h10);
      chk("rd_rw", 32'(bus_rw), 32'd1);
      chk("rd_wd", bus_wr_data, 32'd0);
      addr = 30'h3FFFFFFF; rw = 1'b0;
      tick();
      chk("rd_as2", 32'(bus_as_), 32'd0);
      chk("rd_addr_hold", 32'(bus_addr), 32'h10);
      chk("rd_done2", 32'(done), 32'd0);
      tick();
      chk("rd_as3", 32'(bus_as_), 32'd0);
      chk("rd_done3", 32'(done), 32'd0);
      bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
      tick();
      chk("rd_done", 32'(done), 32'd1);
      chk("rd_data", rd_data, 32'hDEADBEEF);
      chk("rd_as_rel", 32'(bus_as_), 32'd1);
      chk("rd_req_rel", 32'(bus_req_), 32'd1);
      chk("rd_busy_end", 32'(busy), 32'd0);
      req = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = 32'h0BADF00D;
      tick();
      chk_idle("rd_post");
      chk("rd_keep", rd_data, 32'hDEADBEEF);

      // write, grant delayed 5 cycles, ready pulsed before grant
      bus_grnt_ = 1'b1;
      req = 1'b1; rw = 1'b0; addr = 30'h0000100; wr_data = 32'h12345678;
      tick();
      chk("wr_req0", 32'(bus_req_), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus_rdy_ = (i == 1) ? 1'b0 : 1'b1;
         tick();
         chk("wr_wait_req_", 32'(bus_req_), 32'd0);
         chk("wr_wait_as_", 32'(bus_as_), 32'd1);
         chk("wr_wait_wd", bus_wr_data, 32'd0);
         chk("wr_wait_done", 32'(done), 32'd0);
         chk("wr_wait_busy", 32'(busy), 32'd1);
      end
      bus_rdy_ = 1'b1; bus_grnt_ = 1'b0;
      tick();
      chk("wr_as_", 32'(bus_as_), 32'd0);
      chk("wr_wd", bus_wr_data, 32'h12345678);
      chk("wr_rw", 32'(bus_rw), 32'd0);
      chk("wr_addr", 32'(bus_addr), 32'h100);
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b0;
      tick();
      chk("wr_done", 32'(done), 32'd1);
      chk("wr_rd_keep", rd_data, 32'hDEADBEEF);
      chk("wr_as_rel", 32'(bus_as_), 32'd1);
      req = 1'b0;
      tick();
      chk("wr_done_off", 32'(done), 32'd0);

      // back-to-back reads, req held through first done
      bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
      req = 1'b1; rw = 1'b1; addr = 30'h0000020;
      bus_rd_data = 32'h11111111;
      tick();
      tick();
      chk("bb_as1", 32'(bus_as_), 32'd0);
      chk("bb_req_1", 32'(bus_req_), 32'd0);
      tick();
      chk("bb_done1", 32'(done), 32'd1);
      chk("bb_rd1", rd_data, 32'h11111111);
      chk("bb_gap", 32'(bus_req_), 32'd1);
      addr = 30'h0000030; bus_rd_data = 32'h22222222;
      tick();
      chk("bb_req_2", 32'(bus_req_), 32'd0);
      chk("bb_done_off", 32'(done), 32'd0);
      tick();
      chk("bb_addr2", 32'(bus_addr), 32'h30);
      tick();
      chk("bb_done2", 32'(done), 32'd1);
      chk("bb_rd2", rd_data, 32'h22222222);
      req = 1'b0; bus_rdy_ = 1'b1;
      tick();
      chk_idle("bb_post");

      // read that the slave never answers
      req = 1'b1; rw = 1'b1; addr = 30'h0000005;
      tick();
      tick();
      chk("to_as_entry", 32'(bus_as_), 32'd0);
      dcount = 0;
`ifdef BUS_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) dcount++;
      end
      chk("to_early_done", 32'(dcount), 32'd0);
      chk("to_as_hold", 32'(bus_as_), 32'd0);
      tick();
      chk("to_done", 32'(done), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      chk("to_as_rel", 32'(bus_as_), 32'd1);
      chk("to_rd_keep", rd_data, 32'h22222222);
      req = 1'b0;
      tick();
      chk_idle("to_post");
      req = 1'b1;
      tick();
      tick();
`else
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (done || err) dcount++;
      end
      chk("nto_done", 32'(dcount), 32'd0);
      chk("nto_as_", 32'(bus_as_), 32'd0);
      chk("nto_err", 32'(err), 32'd0);
      chk("nto_busy", 32'(busy), 32'd1);
`endif

      // reset for two cycles while in ACCESS
      bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFFFFFF;
      rst_n = 1'b0;
      tick();
      chk_idle("mrst1");
      chk("mrst1_rd", rd_data, 32'd0);
      req = 1'b0;
      tick();
      rst_n = 1'b1; bus_rdy_ = 1'b1;
      tick();
      chk_idle("mrst2");
      chk("mrst2_rd", rd_data, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side bus interface unit: the initiator end of the shared bus protocol (request/grant arbitration, address/select/read-write/write-data drive, slave ready/read-data return).
- Converts a simple core-side access request into one complete bus transaction and returns read data plus a completion pulse.
- One instance sits between each bus master (CPU fetch, CPU data, DMA, debug) and its m*_ port group on the bus.

Parameters:
- ADDR_W, 30, word address width
- DATA_W, 32, data width
- TIMEOUT, 255, max ACCESS cycles before abort; used only with BUS_TIMEOUT_EN; legal range 2..65535

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- req  in  1  core access request; level, held until done
- rw  in  1  1 = read, 0 = write
- addr  in  ADDR_W  core word address
- wr_data  in  DATA_W  core write data
- rd_data  out  DATA_W  last completed read data
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout abort pulse, coincident with done
- busy  out  1  transaction in progress (state != IDLE)
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_addr  out  ADDR_W  bus address
- bus_as_  out  1  address select/strobe, active-low
- bus_rw  out  1  bus read/write, same encoding as rw
- bus_wr_data  out  DATA_W  bus write data
- bus_rd_data  in  DATA_W  read data from slave mux
- bus_rdy_  in  1  slave ready, active-low

Behaviour:
- All outputs registered; all state changes on rising clk.
- Reset values: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_data=0, done=0, err=0, busy=0, state=IDLE.
- State IDLE:
  - If req=1, latch addr, rw and wr_data; set bus_req_=0; go to REQ.
  - req sampled in the cycle done=1 counts as a new request. The core drops req in the done cycle if it has no further access.
- State REQ:
  - Hold bus_req_=0. Bus outputs stay idle (as_=1, addr=0, wr_data=0, rw=1).
  - If bus_grnt_=0: drive latched addr, rw and wr_data (wr_data only for writes, else 0); set bus_as_=0; go to ACCESS.
- State ACCESS:
  - Hold bus_req_=0, bus_as_=0 and the bus fields stable.
  - bus_grnt_ is ignored in this state.
  - If bus_rdy_=0:
    - Read: rd_data <= bus_rd_data. Write: rd_data unchanged.
    - done <= 1 for one cycle.
    - bus_req_ <= 1, bus_as_ <= 1, bus fields return to idle values; go to IDLE.
- Minimum latency, with grant and ready already low: req sampled at edge 0, bus_as_ low after edge 1, done high after edge 2.
- Back-to-back accesses: bus_req_ deasserts for exactly one cycle between transactions, giving the arbiter a rotation point.
- bus_rdy_ seen in IDLE or REQ is ignored.
- Core input changes after latch, while busy=1, are ignored.
- Reset mid-transaction (any state): next edge returns to reset values. No done, no err; rd_data cleared to 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TIMEOUT+1) clears on entry to ACCESS and increments each ACCESS cycle.
  - If bus_rdy_ is still 1 in the TIMEOUT-th ACCESS cycle, the transaction aborts: done=1 and err=1 for one cycle, bus released, rd_data unchanged, go to IDLE.
  - bus_rdy_=0 in that same cycle wins: normal completion, err=0.
- Undefined:
  - No counter exists; err is tied to 0.
  - ACCESS waits for bus_rdy_ indefinitely.

Test Plan:
- rst_n=0 for 2 cycles during an active ACCESS -> after the edge bus_req_=1, bus_as_=1, done=0, err=0, busy=0, rd_data=0.
- Read at addr=30'h0000010, grant immediate, bus_rdy_ low on 3rd ACCESS cycle with bus_rd_data=32'hDEADBEEF -> bus_as_ low exactly 3 cycles, bus_addr=30'h0000010, bus_rw=1, single done pulse, rd_data=32'hDEADBEEF.
- Write of 32'h12345678 to addr=30'h0000100, bus_grnt_ held 1 for 5 cycles -> bus_req_ low throughout, bus_as_=1 and bus_wr_data=0 until grant, then bus_wr_data=32'h12345678 with bus_rw=0; rd_data keeps its previous value.
- Two reads, req held through the first done with the address updated in the done cycle -> bus_req_ high for exactly one cycle between the accesses, two done pulses, rd_data shows the second read's data.
- bus_rdy_=0 pulsed while in REQ (before grant) -> ignored: no done, state stays REQ until grant.
- BUS_TIMEOUT_EN, TIMEOUT=16, bus_rdy_ held 1 -> done=1 and err=1 on the 16th ACCESS cycle, bus released next cycle. Macro undefined -> still in ACCESS with bus_as_=0 after 1000 cycles, err=0.
